mem_requester: RTL and testbench
================================

// Module: mem_requester
// PURPOSE
//   Initiator side of the data-memory interface. Sits between the CPU memory stage
//   and a stallable, multi-cycle memory bank (stall/done handshake). It accepts one
//   word read or write from the stage and issues it to memory, retrying while the
//   bank stalls. It holds the pipeline stalled until the access completes, returns
//   read data, and flags protocol errors.
// PARAMETERS
//   ADDR_W   16   address width (byte address; words are 16 bit, addr[0] must be 0)
//   DATA_W   16   data width
//   TIMEOUT  64   max cycles in WAIT before mem_done; reaching it raises err (>=1)
// PORTS
//   clk         in   1       system clock; everything is rising-edge clocked
//   rst_n       in   1       asynchronous, active-low reset
//   cpu_read    in   1       stage requests a read; held until cpu_done
//   cpu_write   in   1       stage requests a write; held until cpu_done
//   cpu_addr    in   ADDR_W  request address
//   cpu_wdata   in   DATA_W  write data
//   cpu_rdata   out  DATA_W  read data; valid when cpu_done=1, held until next capture
//   cpu_stall   out  1       stage must freeze
//   cpu_done    out  1       one-cycle completion pulse
//   err         out  1       sticky error flag
//   mem_rd      out  1       memory read strobe
//   mem_wr      out  1       memory write strobe
//   mem_addr    out  ADDR_W  latched request address
//   mem_wdata   out  DATA_W  latched write data
//   mem_rdata   in   DATA_W  memory read data; valid with mem_done
//   mem_stall   in   1       bank busy; strobe not accepted this cycle
//   mem_done    in   1       access complete
//   mem_err     in   1       memory-side fault
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE. All outputs 0, including cpu_rdata and err.
//     Any in-flight access is discarded.
//   States: IDLE, ISSUE, WAIT, DONE, ERR.
//   IDLE:
//     - No request: stall=0, stay IDLE.
//     - cpu_read^cpu_write with addr[0]=0: latch op, addr and wdata; go ISSUE.
//       cpu_stall=1 combinationally in this same cycle.
//     - cpu_read&cpu_write, or addr[0]=1: go ERR. No memory strobe is issued.
//   ISSUE:
//     - Drive mem_rd or mem_wr (exactly one) with the latched addr/wdata. stall=1.
//     - mem_stall=1: stay ISSUE and re-strobe next cycle. The retry count is unbounded.
//     - mem_stall=0: the strobe is accepted; go WAIT and clear the timeout counter.
//   WAIT:
//     - Strobes are 0; stall=1; the counter increments each cycle.
//     - mem_done=1: capture mem_rdata (reads only; writes leave cpu_rdata
//       unchanged); go DONE.
//     - mem_err=1 (without mem_done): go ERR.
//     - Counter reaches TIMEOUT: go ERR.
//     - Precedence in one cycle: mem_done > mem_err > timeout.
//   DONE:
//     - cpu_done=1 and stall=0 for exactly one cycle; go IDLE.
//     - Requests in this cycle are ignored. The stage advances on this edge, so the
//       next request is sampled in IDLE on the following cycle.
//   ERR:
//     - err=1, stall=0, done=0, strobes=0. Terminal until rst_n.
//   Minimum latency with zero memory wait (mem_done one cycle after accept):
//     request in IDLE (c0), ISSUE (c1), WAIT + done (c2), DONE pulse (c3).
//   mem_addr and mem_wdata come from registers and are stable from ISSUE through DONE.
//     They are 0 after reset.
//   Counter width: $clog2(TIMEOUT+1). It saturates and never wraps.
// STRUCTURE
//   mem_req_defs.vh: state encodings (3-bit localparams S_IDLE..S_ERR) and
//     OP_READ/OP_WRITE, shared with the pipeline hazard unit.
//   Sub-module timeout_ctr (param MAX; ports clr, en, expired) holds the WAIT counter.
//   Remaining logic is one FSM plus the request latch.
// TESTING
//   1. Read addr 0x0010, memory accepts first strobe, mem_done 2 cycles later with
//      0xBEEF -> stall through WAIT; cpu_done pulses once with cpu_rdata=0xBEEF.
//   2. Write 0x0022 <- 0x1234 with mem_stall=1 for 3 cycles -> 4 consecutive mem_wr
//      cycles, mem_addr=0x0022 and mem_wdata=0x1234 stable throughout; done after
//      mem_done; cpu_rdata unchanged.
//   3. Read at odd addr 0x0013, and separately read&write together -> no mem_rd or
//      mem_wr ever; err=1 next cycle and stays 1; stall=0.
//   4. TIMEOUT=4, memory never sends done -> err rises exactly 4 cycles after
//      entering WAIT. Repeat with mem_done and expiry in the same cycle -> DONE, no err.
//   5. Drop rst_n mid-WAIT -> all outputs 0 immediately; after release, a new read
//      completes normally.
//   6. Back-to-back reads 0x0000, then 0x0002 -> two done pulses separated by a full
//      IDLE/ISSUE/WAIT sequence, each returning its own data.

Source files
------------

// File: rtl/mem_requester_pkg.sv
// mem_requester_pkg: shared definitions for the data-memory requester.
//   state_e  - requester FSM state encodings (3 bit), also visible to the
//              pipeline hazard unit.
//   op_e     - latched operation kind (read / write).
//   req_legal() - true when a stage request may be issued to memory.
package mem_requester_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // Exactly one of read/write, and the byte address must be word aligned.
    function automatic logic req_legal(input logic rd, input logic wr, input logic addr_lsb);
        return (rd ^ wr) && !addr_lsb;
    endfunction

endpackage

// File: rtl/mem_requester_if.sv
// mem_requester_if: bundles the CPU-stage and memory-bank signals of the
// data-memory requester.
//   master modport - the requester (drives cpu_rdata/stall/done/err and the
//                    memory strobes, address and write data).
//   slave modport  - the environment (CPU stage + memory bank).
interface mem_requester_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // CPU stage side
    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              cpu_done;
    logic              err;
    // Memory bank side
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_stall;
    logic              mem_done;
    logic              mem_err;

    modport master (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
        input  mem_rdata, mem_stall, mem_done, mem_err,
        output cpu_rdata, cpu_stall, cpu_done, err,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata,
        output mem_rdata, mem_stall, mem_done, mem_err,
        input  cpu_rdata, cpu_stall, cpu_done, err,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_requester_timeout_ctr.sv
// timeout_ctr: WAIT-phase cycle counter for the memory requester.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - restart the count at zero (strobe accepted)
//   en         - one WAIT cycle elapses
//   expired    - this enabled cycle is the MAX-th one; the FSM leaves WAIT
// The counter is $clog2(MAX+1) bits wide and saturates at MAX.
module timeout_ctr #(
    parameter int MAX = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int              CNT_W = $clog2(MAX + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX - 1);
    localparam logic [CNT_W-1:0] TOP   = CNT_W'(MAX);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise count up until saturation.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != TOP)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of WAIT cycles already spent, so the cycle
    // seeing MAX-1 is the last one allowed.
    assign expired = en && (count_q >= LAST);

endmodule

// File: rtl/mem_requester.sv
// mem_requester: initiator side of the data-memory interface. Accepts one
// word read or write from the CPU memory stage, issues it to a stallable
// multi-cycle bank (re-strobing while mem_stall), stalls the stage until the
// access completes, returns read data and flags protocol errors (sticky).
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - mem_requester_if.master: CPU request/response and memory
//                strobe/handshake signals
// Parameters: ADDR_W/DATA_W bus widths, TIMEOUT max WAIT cycles before err.
module mem_requester
    import mem_requester_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_requester_if.master  bus
);
    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic stall_s;
    logic done_s;
    logic err_s;
    logic rd_s;
    logic wr_s;
    logic ctr_clr_s;
    logic ctr_en_s;
    logic expired_s;

    timeout_ctr #(.MAX(TIMEOUT)) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (ctr_clr_s),
        .en      (ctr_en_s),
        .expired (expired_s)
    );

    // Next-state, request latch and output decode.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        stall_s   = 1'b0;
        done_s    = 1'b0;
        err_s     = 1'b0;
        rd_s      = 1'b0;
        wr_s      = 1'b0;
        ctr_clr_s = 1'b0;
        ctr_en_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_legal(bus.cpu_read, bus.cpu_write, bus.cpu_addr[0])) begin
                    // Stall immediately so the stage freezes in the request cycle.
                    stall_s = 1'b1;
                    op_d    = bus.cpu_write ? OP_WRITE : OP_READ;
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    state_d = S_ISSUE;
                end else if (bus.cpu_read || bus.cpu_write) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                stall_s = 1'b1;
                rd_s    = (op_q == OP_READ);
                wr_s    = (op_q == OP_WRITE);
                if (!bus.mem_stall) begin
                    ctr_clr_s = 1'b1;
                    state_d   = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                stall_s  = 1'b1;
                ctr_en_s = 1'b1;
                // mem_done beats mem_err beats timeout.
                if (bus.mem_done) begin
                    if (op_q == OP_READ) begin
                        rdata_d = bus.mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = S_DONE;
                end else if (bus.mem_err || expired_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                done_s  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err_s   = 1'b1;
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // State and request/response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // The IDLE-cycle stall follows the live request, so gate it with reset
    // to keep every output at 0 while rst_n is low.
    assign bus.cpu_stall = stall_s & rst_n;
    assign bus.cpu_done  = done_s;
    assign bus.err       = err_s;
    assign bus.cpu_rdata = rdata_q;
    assign bus.mem_rd    = rd_s;
    assign bus.mem_wr    = wr_s;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: directed scoreboard bench for mem_requester (TIMEOUT=4).
// Stimulus tasks push the expected completion (done + read data, or error)
// into exp_q; the monitor pops on every cpu_done pulse and every err rise.
module tb_mem_requester;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 4;

    typedef struct packed {
        logic          is_err;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic err_prev = 1'b0;

    always #5 clk = ~clk;

    mem_requester_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_requester #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: completions and error rises consume expectations.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            err_prev = 1'b0;
        end else begin
            if (bus.cpu_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with rdata 0x%0h, expected none", bus.cpu_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("done_kind", {31'd0, e.is_err}, 32'd0);
                    check("done_rdata", {16'd0, bus.cpu_rdata}, {16'd0, e.rdata});
                end
            end
            if (bus.err === 1'b1 && err_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_err: got err rise, expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("err_kind", {31'd0, e.is_err}, 32'd1);
                end
            end
            err_prev = bus.err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_wdata = 16'h0000;
        bus.mem_rdata = 16'h0000;
        bus.mem_stall = 1'b0;
        bus.mem_done  = 1'b0;
        bus.mem_err   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, {31'd0, bus.cpu_stall}, 32'd0);
        check({tag, "_done"},  {31'd0, bus.cpu_done},  32'd0);
        check({tag, "_err"},   {31'd0, bus.err},       32'd0);
        check({tag, "_strobes"}, {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
        check({tag, "_rdata"}, {16'd0, bus.cpu_rdata}, 32'd0);
        check({tag, "_addr"},  {16'd0, bus.mem_addr},  32'd0);
        check({tag, "_wdata"}, {16'd0, bus.mem_wdata}, 32'd0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
    endtask

    // One full access starting in IDLE (call at posedge+1). n_stall stalled
    // ISSUE cycles, then mem_done in WAIT cycle n_wait. Returns in IDLE.
    task automatic do_access(input logic is_wr, input logic [15:0] addr, input logic [15:0] wdata,
                             input int n_stall, input int n_wait,
                             input logic [15:0] mdata, input logic [15:0] exp_rdata);
        int strobes;
        strobes = 0;
        bus.cpu_read  = ~is_wr;
        bus.cpu_write = is_wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        exp_q.push_back({1'b0, exp_rdata});
        @(negedge clk);
        check("idle_stall", {31'd0, bus.cpu_stall}, 32'd1);
        check("idle_strobes", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
        for (int i = 0; i <= n_stall; i++) begin
            tick();
            bus.mem_stall = (i < n_stall);
            @(negedge clk);
            if (bus.mem_rd || bus.mem_wr) strobes++;
            check("issue_strobe", {30'd0, bus.mem_rd, bus.mem_wr}, is_wr ? 32'd1 : 32'd2);
            check("issue_addr", {16'd0, bus.mem_addr}, {16'd0, addr});
            check("issue_wdata", {16'd0, bus.mem_wdata}, {16'd0, wdata});
            check("issue_stall", {31'd0, bus.cpu_stall}, 32'd1);
        end
        check("strobe_count", strobes, n_stall + 1);
        for (int i = 0; i <= n_wait; i++) begin
            tick();
            bus.mem_stall = 1'b0;
            bus.mem_done  = (i == n_wait);
            bus.mem_rdata = (i == n_wait) ? mdata : 16'hDEAD;
            @(negedge clk);
            check("wait_stall", {31'd0, bus.cpu_stall}, 32'd1);
            check("wait_strobes", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
            check("wait_no_done", {31'd0, bus.cpu_done}, 32'd0);
        end
        tick();
        bus.mem_done  = 1'b0;
        bus.mem_rdata = 16'h0000;
        @(negedge clk);
        check("done_pulse", {31'd0, bus.cpu_done}, 32'd1);
        check("done_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check("done_addr", {16'd0, bus.mem_addr}, {16'd0, addr});
        check("done_wdata", {16'd0, bus.mem_wdata}, {16'd0, wdata});
        tick();
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    // Illegal request from IDLE: no strobe ever, err from the next cycle on.
    task automatic bad_request(input logic rd, input logic wr, input logic [15:0] addr);
        bus.cpu_read  = rd;
        bus.cpu_write = wr;
        bus.cpu_addr  = addr;
        exp_q.push_back({1'b1, 16'h0000});
        @(negedge clk);
        check("bad_req_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check("bad_req_strobes", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
        check("bad_req_err_early", {31'd0, bus.err}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("bad_err_sticky", {31'd0, bus.err}, 32'd1);
            check("bad_stall", {31'd0, bus.cpu_stall}, 32'd0);
            check("bad_strobes", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
            check("bad_no_done", {31'd0, bus.cpu_done}, 32'd0);
        end
        tick();
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        reset_dut();

        // Read with one idle WAIT cycle before mem_done.
        do_access(1'b0, 16'h0010, 16'h0000, 0, 1, 16'hBEEF, 16'hBEEF);
        // Write stalled 3 times; read data register must keep 0xBEEF.
        do_access(1'b1, 16'h0022, 16'h1234, 3, 0, 16'h0BAD, 16'hBEEF);
        // Back-to-back reads.
        do_access(1'b0, 16'h0000, 16'h0000, 0, 0, 16'h1111, 16'h1111);
        do_access(1'b0, 16'h0002, 16'h0000, 0, 1, 16'h2222, 16'h2222);

        // Reset in the middle of WAIT with the request still held.
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 16'h0030;
        tick();
        bus.mem_stall = 1'b0;
        tick();
        @(negedge clk);
        check("prereset_wait_stall", {31'd0, bus.cpu_stall}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midwait_reset");
        bus.cpu_read = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        do_access(1'b0, 16'h0030, 16'h0000, 0, 0, 16'h7777, 16'h7777);

        // Illegal requests.
        reset_dut();
        bad_request(1'b1, 1'b0, 16'h0013);
        reset_dut();
        bad_request(1'b1, 1'b1, 16'h0010);

        // Timeout: memory never answers.
        reset_dut();
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 16'h0040;
        exp_q.push_back({1'b1, 16'h0000});
        tick();
        bus.mem_stall = 1'b0;
        @(negedge clk);
        check("to_issue_strobe", {31'd0, bus.mem_rd}, 32'd1);
        for (int w = 0; w <= 4; w++) begin
            tick();
            @(negedge clk);
            if (w < 4) begin
                check("to_wait_err", {31'd0, bus.err}, 32'd0);
                check("to_wait_stall", {31'd0, bus.cpu_stall}, 32'd1);
            end else begin
                check("to_err_rise", {31'd0, bus.err}, 32'd1);
                check("to_err_stall", {31'd0, bus.cpu_stall}, 32'd0);
            end
        end
        tick();
        bus.cpu_read = 1'b0;

        // mem_done in the same cycle the timeout expires: done wins.
        reset_dut();
        do_access(1'b0, 16'h0040, 16'h0000, 0, 3, 16'h5A5A, 16'h5A5A);
        @(negedge clk);
        check("tie_no_err", {31'd0, bus.err}, 32'd0);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
